// File: rtl/parent_pkg.sv
// rtl/parent_pkg.sv - shared state encodings and widths for the multi-kid parent
package parent_pkg;

    localparam logic [1:0] ST_SLEEP = 2'd0;
    localparam logic [1:0] ST_COOK  = 2'd1;
    localparam logic [1:0] ST_SERVE = 2'd2;

    localparam int STATS_W = 16;

endpackage

// File: rtl/parent_rr_pick.sv
// rtl/parent_rr_pick.sv - combinational round-robin picker: first eligible index at or above rr_ptr, wrapping
module parent_rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] rr_ptr,
    output logic [PW-1:0] grant,
    output logic          valid
);

    logic [PW:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            // One extra bit so the sum can exceed N before folding back
            idx = {1'b0, rr_ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!valid && eligible[idx[PW-1:0]]) begin
                valid = 1'b1;
                grant = idx[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/parent_multi.sv
// rtl/parent_multi.sv - multi-kid sleep/cook/serve parent; PARENT_STATS_EN adds the served_cnt port
module parent_multi
    import parent_pkg::*;
#(
    parameter int N_KIDS      = 4,
    parameter int COOK_CYCLES = 3,
    parameter int BATCH       = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic [N_KIDS-1:0] hungry,
    output logic [N_KIDS-1:0] food,
    output logic [1:0]        state,
    output logic              busy
`ifdef PARENT_STATS_EN
    ,
    output logic [STATS_W-1:0] served_cnt
`endif
);

    localparam int PTR_W = (N_KIDS > 1) ? $clog2(N_KIDS) : 1;
    localparam logic [N_KIDS-1:0] ONE = N_KIDS'(1);

    logic [1:0]        state_q, state_d;
    logic [N_KIDS-1:0] food_q, food_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cook_cnt_q, cook_cnt_d;
    logic [CNT_W-1:0]  portions_q, portions_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic [N_KIDS-1:0] eligible;
    logic [N_KIDS-1:0] grant_oh;
    logic [PTR_W-1:0]  grant;
    logic              pick_valid;

    // A kid being fed this cycle is masked so it cannot be granted back-to-back
    assign eligible = hungry & ~food_q;
    assign grant_oh = ONE << grant;

    parent_rr_pick #(
        .N  (N_KIDS),
        .PW (PTR_W)
    ) u_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_q),
        .grant    (grant),
        .valid    (pick_valid)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= ST_SLEEP;
            food_q     <= '0;
            busy_q     <= 1'b0;
            cook_cnt_q <= '0;
            portions_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            food_q     <= food_d;
            busy_q     <= busy_d;
            cook_cnt_q <= cook_cnt_d;
            portions_q <= portions_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cook_cnt_d = cook_cnt_q;
        portions_d = portions_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            ST_SLEEP: begin
                if (|hungry) begin
                    state_d    = ST_COOK;
                    cook_cnt_d = '0;
                end
            end
            ST_COOK: begin
                if (cook_cnt_q == CNT_W'(COOK_CYCLES - 1)) begin
                    state_d    = ST_SERVE;
                    portions_d = CNT_W'(BATCH);
                    cook_cnt_d = '0;
                end else begin
                    cook_cnt_d = cook_cnt_q + 1'b1;
                end
            end
            ST_SERVE: begin
                if (pick_valid) begin
                    rr_ptr_d   = (grant == PTR_W'(N_KIDS - 1)) ? '0 : grant + 1'b1;
                    portions_d = portions_q - 1'b1;
                    // Last portion: cook again only if someone other than this kid still waits
                    if (portions_q <= CNT_W'(1)) begin
                        portions_d = '0;
                        cook_cnt_d = '0;
                        state_d    = (|(eligible & ~grant_oh)) ? ST_COOK : ST_SLEEP;
                    end
                end else begin
                    state_d    = ST_SLEEP;
                    portions_d = '0;
                end
            end
            default: begin
                state_d    = ST_SLEEP;
                cook_cnt_d = '0;
                portions_d = '0;
            end
        endcase
    end

    always_comb begin
        food_d = '0;
        if (state_q == ST_SERVE && pick_valid) begin
            food_d = grant_oh;
        end
        busy_d = (state_d != ST_SLEEP);
    end

`ifdef PARENT_STATS_EN
    logic [STATS_W-1:0] served_q, served_d;

    always_comb begin
        served_d = served_q;
        if (|food_d && served_q != {STATS_W{1'b1}}) begin
            served_d = served_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            served_q <= '0;
        end else begin
            served_q <= served_d;
        end
    end

    assign served_cnt = served_q;
`endif

    assign food  = food_q;
    assign state = state_q;
    assign busy  = busy_q;

endmodule

// File: doc/parent_multi.md
Name: parent_multi

Overview:
- Parametrised successor to the single-child sleep/cook parent FSM. It serves N_KIDS children, each raising its own hunger request.
- It cooks in timed batches of BATCH portions, then hands out one portion per cycle in round-robin order.
- Sits between the kid request bus and the food delivery bus in the household model. All outputs are registered.

Parameters:
- N_KIDS, 4, number of request/food channels (>=2)
- COOK_CYCLES, 3, cycles spent in COOK per batch (>=1)
- BATCH, 2, portions produced per cook batch (>=1)
- CNT_W, 8, width of cook/portion counters; must hold max(COOK_CYCLES, BATCH)

Ports:
- clk  in  1  rising-edge clock
- resetb  in  1  asynchronous active-low reset
- hungry  in  N_KIDS  per-kid level request; kid holds until it sees its food bit
- food  out  N_KIDS  registered one-hot (or zero) serve pulse, one cycle per portion
- state  out  2  current state: SLEEP=0, COOK=1, SERVE=2 (3 unused, recovers to SLEEP)
- busy  out  1  registered, high when state != SLEEP

Behaviour:
- Reset (resetb low, asynchronous): state=SLEEP, food=0, busy=0, cook_cnt=0, portions=0, rr_ptr=0. Reset mid-COOK/SERVE aborts immediately; no food pulse after release until a new batch is cooked.
- eligible = hungry & ~food. A kid currently receiving food is never re-granted in the same cycle.
- SLEEP: if |hungry at a rising edge -> COOK, cook_cnt=0; else stay.
- COOK: cook_cnt increments each edge. At the edge where cook_cnt==COOK_CYCLES-1 -> SERVE, portions=BATCH, cook_cnt=0. If COOK is entered at edge E, SERVE is entered at E+COOK_CYCLES. Hunger dropping during COOK does not abort cooking.
- SERVE, each edge:
  - if eligible!=0: grant = first set bit of eligible searching upward from rr_ptr, with wrap-around. food<=onehot(grant); rr_ptr<=grant+1 mod N_KIDS; portions decrements.
    - If portions becomes 0: next state COOK if (eligible & ~onehot(grant))!=0, else SLEEP.
  - if eligible==0: food<=0 and -> SLEEP. Leftover portions are discarded (portions=0).
- First food pulse appears at edge E+COOK_CYCLES+1. Consecutive grants go to distinct kids when more than one is eligible.
- A single hungry kid gets at most one pulse every 2 cycles, because of the ~food mask. If it keeps hungry high, it is served again.
- food is 0 in every state except the cycle after a SERVE grant. At most one bit is ever set.
- Illegal state 3 -> SLEEP on the next edge, food=0.

Optional Feature:
- Macro PARENT_STATS_EN.
- Defined: adds output port served_cnt (16 bits). It increments on every food pulse, saturates at 0xFFFF, and resets to 0.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Package parent_pkg:
  - state encodings ST_SLEEP/ST_COOK/ST_SERVE (2-bit localparams)
  - STATS_W=16
- One natural sub-module: parent_rr_pick. It is combinational, parameter N, with inputs eligible and rr_ptr, and outputs grant index and valid.
- All sequential logic stays in parent_multi.

Test Plan:
- Reset then hungry=0001 held: COOK entered at edge E; food=0001 exactly at E+4 (COOK_CYCLES=3); after drop, food returns to 0 and state returns to SLEEP.
- hungry=1111 held, BATCH=2: pulses 0001, 0010; then COOK for 3 cycles; then 0100, 1000; then 0001. Round-robin pointer wraps correctly.
- hungry=0101 from SLEEP, kids drop on their food pulse: pulses 0001 then 0100; remaining requests 0 -> SLEEP; busy falls the same edge.
- Hunger pulled to 0000 during COOK: cook completes, SERVE sees eligible=0 -> SLEEP with no food pulse.
- resetb asserted mid-SERVE with a pending grant: food, busy and state go 0 immediately (asynchronously); after release with hungry=0010, a full COOK precedes any food.
- PARENT_STATS_EN build, 5 served portions: served_cnt=5. Forced near 0xFFFF, the counter saturates and does not wrap.
